// File: rtl/draw_rect_img.sv
// draw_rect_img: overlays a RECT_W x RECT_H image from a synchronous ROM onto the VGA stream at a per-frame latched position
// Ports: clk/rst (sync, active-high); xpos/ypos rectangle origin; *_in timing stream and rgb_in background;
// rgb_address/rgb_pixel image ROM interface (data one cycle after address); frame_tick on vblnk rise;
// *_out stream delayed two cycles; rgb_out merged pixel.
// The final merge reads rgb_pixel straight from the ROM register, so the pixel lines up with the stage-2 stream.
module draw_rect_img #(
  parameter int          RECT_W  = 100,
  parameter int          RECT_H  = 100,
  parameter bit          KEY_EN  = 1'b1,
  parameter logic [11:0] KEY_RGB = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  output logic [13:0] rgb_address,
  input  logic [11:0] rgb_pixel,
  output logic        frame_tick,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);
  logic        vblnk_r, in_rect, in_rect_1, in_rect_2;
  logic [11:0] x_l, y_l, rgb_1, rgb_2;
  logic [12:0] h13, v13, x0, y0, x1, y1;
  logic [13:0] dx, dy, addr_next;
  logic [10:0] vc_1, hc_1;
  logic        vs_1, hs_1, vb_1, hb_1;
  logic        vb_rise;
  assign vb_rise = vblnk_in && !vblnk_r;
  // 13-bit bounds so a rectangle near the right/bottom edge clips instead of wrapping
  assign h13 = {2'b00, hcount_in};
  assign v13 = {2'b00, vcount_in};
  assign x0 = {1'b0, x_l};
  assign y0 = {1'b0, y_l};
  assign x1 = x0 + 13'(RECT_W);
  assign y1 = y0 + 13'(RECT_H);
  assign in_rect = h13 >= x0 && h13 < x1 && v13 >= y0 && v13 < y1 && !hblnk_in && !vblnk_in;
  assign dx = {1'b0, h13 - x0};
  assign dy = {1'b0, v13 - y0};
  assign addr_next = dy * 14'(RECT_W) + dx;
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_r     <= 1'b0;
      frame_tick  <= 1'b0;
      x_l         <= '0;
      y_l         <= '0;
      rgb_address <= '0;
      in_rect_1   <= 1'b0;
      vc_1        <= '0;
      hc_1        <= '0;
      vs_1        <= 1'b0;
      hs_1        <= 1'b0;
      vb_1        <= 1'b0;
      hb_1        <= 1'b0;
      rgb_1       <= '0;
      in_rect_2   <= 1'b0;
      vcount_out  <= '0;
      hcount_out  <= '0;
      vsync_out   <= 1'b0;
      hsync_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      hblnk_out   <= 1'b0;
      rgb_2       <= '0;
    end else begin
      vblnk_r     <= vblnk_in;
      frame_tick  <= vb_rise;
      x_l         <= vb_rise ? xpos : x_l;
      y_l         <= vb_rise ? ypos : y_l;
      rgb_address <= in_rect ? addr_next : rgb_address;
      in_rect_1   <= in_rect;
      vc_1        <= vcount_in;
      hc_1        <= hcount_in;
      vs_1        <= vsync_in;
      hs_1        <= hsync_in;
      vb_1        <= vblnk_in;
      hb_1        <= hblnk_in;
      rgb_1       <= rgb_in;
      in_rect_2   <= in_rect_1;
      vcount_out  <= vc_1;
      hcount_out  <= hc_1;
      vsync_out   <= vs_1;
      hsync_out   <= hs_1;
      vblnk_out   <= vb_1;
      hblnk_out   <= hb_1;
      rgb_2       <= rgb_1;
    end
  end
  always_comb begin
    rgb_out = (hblnk_out || vblnk_out) ? 12'h000 :
              (in_rect_2 && !(KEY_EN && rgb_pixel == KEY_RGB)) ? rgb_pixel : rgb_2;
  end
endmodule

// File: tb/tb_draw_rect_img.sv
// tb_draw_rect_img: directed table-driven bench for draw_rect_img with keyed and unkeyed instances
module tb_draw_rect_img;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos, rgb_in;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
  logic [13:0] addr_k, addr_n;
  logic [11:0] pix_k, pix_n, out_k, out_n;
  logic        tick_k, tick_n_o;
  logic [10:0] vc_o, hc_o, vc_n, hc_n;
  logic        vs_o, hs_o, vb_o, hb_o, vs_n, hs_n, vb_n, hb_n;
  logic        rom_sel;
  logic [11:0] rom_fixed;
  int          checks = 0;
  int          failures = 0;
  int          cnt;
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    pix_k <= rom_sel ? rom_fixed : addr_k[11:0];
    pix_n <= rom_sel ? rom_fixed : addr_n[11:0];
  end
  draw_rect_img u_dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .vcount_in(vcount_in), .hcount_in(hcount_in), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .vblnk_in(vblnk_in), .hblnk_in(hblnk_in), .rgb_in(rgb_in),
    .rgb_address(addr_k), .rgb_pixel(pix_k), .frame_tick(tick_k),
    .vcount_out(vc_o), .hcount_out(hc_o), .vsync_out(vs_o), .hsync_out(hs_o),
    .vblnk_out(vb_o), .hblnk_out(hb_o), .rgb_out(out_k)
  );
  draw_rect_img #(.KEY_EN(1'b0)) u_nokey (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .vcount_in(vcount_in), .hcount_in(hcount_in), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .vblnk_in(vblnk_in), .hblnk_in(hblnk_in), .rgb_in(rgb_in),
    .rgb_address(addr_n), .rgb_pixel(pix_n), .frame_tick(tick_n_o),
    .vcount_out(vc_n), .hcount_out(hc_n), .vsync_out(vs_n), .hsync_out(hs_n),
    .vblnk_out(vb_n), .hblnk_out(hb_n), .rgb_out(out_n)
  );
  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hb;
    logic        vb;
    logic        sel;
    logic [11:0] rgb;
    logic [11:0] exp_k;
    logic [11:0] exp_n;
  } vec_t;
  vec_t v[12];
  task automatic drive(input logic [10:0] hc, input logic [10:0] vc, input logic hb, input logic vb, input logic [11:0] rgb);
    hcount_in = hc;
    vcount_in = vc;
    hsync_in  = hc[0];
    vsync_in  = vc[0];
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic pix(input string name, input logic [10:0] hc, input logic [10:0] vc, input logic hb, input logic [11:0] rgb, input logic [11:0] exp);
    drive(hc, vc, hb, 1'b0, rgb);
    step(3);
    chk(name, 64'(out_k), 64'(exp));
  endtask
  initial begin
    // x_l = y_l = 350, RECT 100x100; unforced ROM returns address[11:0]
    v[0]  = '{11'd360, 11'd355, 1'b0, 1'b0, 1'b0, 12'h111, 12'h1FE, 12'h1FE};
    v[1]  = '{11'd349, 11'd355, 1'b0, 1'b0, 1'b0, 12'h123, 12'h123, 12'h123};
    v[2]  = '{11'd450, 11'd355, 1'b0, 1'b0, 1'b0, 12'h456, 12'h456, 12'h456};
    v[3]  = '{11'd350, 11'd355, 1'b0, 1'b0, 1'b0, 12'h999, 12'h1F4, 12'h1F4};
    v[4]  = '{11'd449, 11'd355, 1'b0, 1'b0, 1'b0, 12'h999, 12'h257, 12'h257};
    v[5]  = '{11'd360, 11'd349, 1'b0, 1'b0, 1'b0, 12'h789, 12'h789, 12'h789};
    v[6]  = '{11'd360, 11'd350, 1'b0, 1'b0, 1'b0, 12'h999, 12'h00A, 12'h00A};
    v[7]  = '{11'd360, 11'd449, 1'b0, 1'b0, 1'b0, 12'h999, 12'h6B6, 12'h6B6};
    v[8]  = '{11'd360, 11'd450, 1'b0, 1'b0, 1'b0, 12'h321, 12'h321, 12'h321};
    v[9]  = '{11'd360, 11'd355, 1'b0, 1'b0, 1'b1, 12'h0F0, 12'h0F0, 12'hF0F};
    v[10] = '{11'd360, 11'd355, 1'b1, 1'b0, 1'b0, 12'h777, 12'h000, 12'h000};
    v[11] = '{11'd360, 11'd355, 1'b0, 1'b1, 1'b0, 12'h777, 12'h000, 12'h000};
    rst = 1'b1;
    xpos = '0;
    ypos = '0;
    rom_sel = 1'b0;
    rom_fixed = 12'hF0F;
    drive('0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      xpos = 12'($urandom);
      ypos = 12'($urandom);
      drive(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
      step(1);
    end
    chk("reset_outputs", 64'({addr_k, tick_k, vc_o, hc_o, vs_o, hs_o, vb_o, hb_o, out_k}), 64'd0);
    rst = 1'b0;
    xpos = '0;
    ypos = '0;
    for (int k = 0; k < 6; k++) begin
      drive(11'(100 + k), 11'd5, 1'b0, 1'b0, 12'h000);
      step(1);
      if (k >= 1) chk("latency_hcount", 64'(hc_o), 64'(100 + k - 1));
    end
    xpos = 12'd350;
    ypos = 12'd350;
    drive(11'd0, 11'd0, 1'b0, 1'b1, 12'h000);
    step(1);
    chk("tick_rise", 64'(tick_k), 64'd1);
    step(1);
    chk("tick_single", 64'(tick_k), 64'd0);
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
    step(1);
    drive(11'd360, 11'd355, 1'b0, 1'b0, 12'h111);
    step(1);
    chk("address_510", 64'(addr_k), 64'd510);
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h222);
    step(1);
    chk("rom_at_n2", 64'(out_k), 64'h1FE);
    chk("hcount_at_n2", 64'(hc_o), 64'd360);
    step(1);
    chk("outside_after", 64'(out_k), 64'h222);
    for (int i = 0; i < 12; i++) begin
      rom_sel = v[i].sel;
      drive(v[i].hc, v[i].vc, v[i].hb, v[i].vb, v[i].rgb);
      step(3);
      chk($sformatf("vec%0d_rgb", i), 64'(out_k), 64'(v[i].exp_k));
      chk($sformatf("vec%0d_rgb_nokey", i), 64'(out_n), 64'(v[i].exp_n));
      chk($sformatf("vec%0d_stream", i), 64'({vc_o, hc_o, vs_o, hs_o, vb_o, hb_o}),
          64'({v[i].vc, v[i].hc, v[i].vc[0], v[i].hc[0], v[i].vb, v[i].hb}));
    end
    rom_sel = 1'b0;
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
    step(1);
    xpos = 12'd351;
    pix("midframe_hold", 11'd350, 11'd355, 1'b0, 12'h333, 12'h1F4);
    cnt = 0;
    drive(11'd350, 11'd355, 1'b0, 1'b1, 12'h333);
    for (int i = 0; i < 4; i++) begin
      step(1);
      cnt += int'(tick_k);
    end
    chk("one_tick_per_frame", 64'(cnt), 64'd1);
    pix("relatched_old_x", 11'd350, 11'd355, 1'b0, 12'h333, 12'h333);
    pix("relatched_new_x", 11'd351, 11'd355, 1'b0, 12'h333, 12'h1F4);
    drive(11'd351, 11'd355, 1'b0, 1'b1, 12'h333);
    step(2);
    xpos = 12'd600;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      cnt += int'(tick_k);
    end
    chk("no_tick_held_vblnk", 64'(cnt), 64'd0);
    pix("no_relatch_held", 11'd351, 11'd355, 1'b0, 12'h333, 12'h1F4);
    xpos = 12'd1000;
    drive(11'd0, 11'd355, 1'b0, 1'b1, 12'h000);
    step(2);
    pix("clip_1000", 11'd1000, 11'd355, 1'b0, 12'h444, 12'h1F4);
    pix("clip_1023", 11'd1023, 11'd355, 1'b0, 12'h444, 12'h20B);
    pix("nowrap_0", 11'd0, 11'd355, 1'b0, 12'h444, 12'h444);
    pix("nowrap_75", 11'd75, 11'd355, 1'b0, 12'h555, 12'h555);
    pix("hblnk_in_rect", 11'd1010, 11'd355, 1'b1, 12'h666, 12'h000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
